axi_lite_rd_arbiter: RTL and testbench
======================================

Name: axi_lite_rd_arbiter

Overview:
Two-master to one-slave arbiter for the AXI-lite read channels. It shares the single memory slave between instruction fetch (M0) and load/store (M1). Arbitration is round-robin. Flushes on the M0 side drop in-flight fetches without breaking the slave handshake. M1 reads are held off while the write path has a store outstanding, which keeps load-after-store ordering.

Parameters:
ADDR_WIDTH, 32, address width of every ar_addr
DATA_WIDTH, 32, width of every rd_data

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
flush  input  1  pipeline flush; affects M0 only
wr_pending  input  1  write path has an unfinished store; masks M1 read requests
m0_ar_valid  input  1  M0 read request
m0_ar_ready  output  1  M0 request accepted
m0_ar_addr  input  ADDR_WIDTH  M0 read address
m0_rd_valid  output  1  M0 read data valid
m0_rd_ready  input  1  M0 can take data
m0_rd_data  output  DATA_WIDTH  M0 read data
m1_ar_valid / m1_ar_ready / m1_ar_addr / m1_rd_valid / m1_rd_ready / m1_rd_data  same as M0, for master M1
s_ar_valid  output  1  slave request
s_ar_ready  input  1  slave accepts request
s_ar_addr  output  ADDR_WIDTH  latched address of the granted master
s_ar_prot  output  3  3'b100 when M0 is granted (instruction), 3'b000 when M1 is granted
s_rd_valid  input  1  slave data valid
s_rd_ready  output  1  ready toward slave
s_rd_data  input  DATA_WIDTH  slave data

Behaviour:
- Reset is sampled at posedge clk.
  - While reset=0: state=IDLE, grant=M1, last_grant=M1, drop=0, addr_q=0.
  - All valid/ready outputs are 0; rd_data outputs pass s_rd_data.
- Effective requests: req0 = m0_ar_valid & ~flush; req1 = m1_ar_valid & ~wr_pending.
- IDLE:
  - Only one request asserted: that master wins.
  - Both asserted: the master not equal to last_grant wins. After reset this is M0.
  - The winner's mX_ar_ready=1 combinationally in the same cycle, so the handshake completes there.
  - On that posedge: addr_q <= winner addr, grant <= winner, last_grant <= winner, state -> ADDR.
  - No request: stay IDLE; both ar_ready=0.
- ADDR:
  - s_ar_valid=1, s_ar_addr=addr_q, s_ar_prot per grant. Both m*_ar_ready=0.
  - s_ar_valid stays high until s_ar_ready is seen. On s_ar_ready: -> DATA.
- DATA:
  - Normal case: mG_rd_valid = s_rd_valid and s_rd_ready = mG_rd_ready, where G is the granted master. The non-granted master's rd_valid=0.
  - If drop=1: mG_rd_valid=0 and s_rd_ready=1, so the beat is discarded.
  - On s_rd_valid & s_rd_ready: -> IDLE, drop <= 0.
  - Back-to-back: the earliest next grant is the cycle after the DATA handshake, when the FSM is in IDLE. One transaction is outstanding at most.
- Flush:
  - flush=1 while grant=M0 and state is ADDR or DATA sets drop <= 1. It is sticky until the transaction ends.
  - The slave transaction is always completed, never aborted.
  - If flush=1 in the same cycle as the DATA handshake, that beat is not delivered to M0 (drop applies combinationally that cycle).
  - flush=1 in IDLE blocks M0 grant that cycle.
  - Flush never affects an M1 transaction.
- wr_pending:
  - Evaluated only in IDLE.
  - Rising mid-transaction has no effect on an already-granted M1 read.
  - M0 is never blocked by wr_pending.
- Arbitration fairness: with both requesting continuously, grants strictly alternate M0, M1, M0, ...
- Reset mid-transaction: FSM returns to IDLE immediately, drop cleared, s_ar_valid drops. The slave is reset by the same signal.
- rd_data: both m0_rd_data and m1_rd_data are driven directly from s_rd_data. Qualify with rd_valid.

Test Plan:
- Single M0 read, addr 0x8000_0000, slave returns 0x1234_5678 one cycle later: m0_ar_ready high in the request cycle; s_ar_addr=0x8000_0000, s_ar_prot=3'b100; m0_rd_valid with 0x1234_5678; m1_rd_valid stays 0.
- M0 and M1 both request continuously from reset: grant order M0, M1, M0, M1; s_ar_prot alternates 100/000; each master's data goes only to that master.
- M0 read granted, flush pulsed during ADDR: slave still sees one s_ar_valid/s_ar_ready pair and one rd beat with s_rd_ready=1; m0_rd_valid never asserts; FSM returns to IDLE; next M0 request is granted normally.
- wr_pending=1 with M1 and M0 requesting: M0 granted, M1 not. Drop wr_pending: M1 granted in the next IDLE cycle.
- M1 read with m1_rd_ready held low for 3 cycles while s_rd_valid=1: s_rd_ready=0 for those cycles, the data stays presented, the handshake completes when ready rises, then IDLE.
- reset=0 asserted during DATA: next cycle state=IDLE, s_ar_valid=0, all ready/valid outputs 0; after release, the first tie is granted to M0.

Source files
------------

// File: rtl/axi_lite_rd_arbiter_if.sv
// AXI-lite read channel bundle (AR + R) for one master/slave link.
//
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid and ready are both high. A source raises valid without
// waiting for ready and holds valid and its payload steady until that edge.
// A sink may raise or drop ready at any time.
interface axi_lite_rd_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]            ar_prot;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    // Side that issues read requests and consumes read data.
    modport master (
        output ar_valid, ar_addr, ar_prot, rd_ready,
        input  ar_ready, rd_valid, rd_data
    );

    // Side that accepts read requests and returns read data.
    modport slave (
        input  ar_valid, ar_addr, ar_prot, rd_ready,
        output ar_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// Two-master, one-slave AXI-lite read arbiter.
// M0 is instruction fetch and M1 is load/store. Ties are broken round-robin.
// A flush aimed at M0 marks the in-flight fetch for discard, and the slave
// handshake still runs to completion. M1 requests are masked while a store
// is outstanding, so a load cannot pass an earlier store.
// At most one transaction is outstanding.
module axi_lite_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    wr_pending,
    axi_lite_rd_arbiter_if.slave    m0,
    axi_lite_rd_arbiter_if.slave    m1,
    axi_lite_rd_arbiter_if.master   s,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [2:0] PROT_INSN = 3'b100;
    localparam logic [2:0] PROT_DATA = 3'b000;

    state_t                state;
    logic                  grant_m0;     // 1: M0 owns the transaction, 0: M1
    logic                  last_m0;      // 1: most recent grant went to M0
    logic                  drop;         // discard the M0 data beat
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  ar_valid_q;
    logic [2:0]            prot_q;

    logic                  req0;
    logic                  req1;
    logic                  win0;
    logic                  win1;
    logic                  drop_now;
    logic                  s_rd_ready_int;
    logic                  rd_hs;

    // Request masking and the round-robin pick for the IDLE cycle.
    always_comb begin
        req0     = m0.ar_valid & ~flush;
        req1     = m1.ar_valid & ~wr_pending;
        // On a tie the master that did not win last time is chosen.
        win0     = req0 & (~req1 | ~last_m0);
        win1     = req1 & ~win0;
        // A flush in the handshake cycle itself also stops delivery to M0.
        drop_now = drop | (grant_m0 & flush);
    end

    // Request/data steering. All valid/ready outputs are held low during reset.
    always_comb begin
        m0.ar_ready    = 1'b0;
        m1.ar_ready    = 1'b0;
        m0.rd_valid    = 1'b0;
        m1.rd_valid    = 1'b0;
        s_rd_ready_int = 1'b0;
        if (reset) begin
            if (state == IDLE) begin
                m0.ar_ready = win0;
                m1.ar_ready = win1;
            end
            if (state == DATA) begin
                if (grant_m0) begin
                    m0.rd_valid    = s.rd_valid & ~drop_now;
                    s_rd_ready_int = drop_now | m0.rd_ready;
                end else begin
                    m1.rd_valid    = s.rd_valid;
                    s_rd_ready_int = m1.rd_ready;
                end
            end
        end
        rd_hs = s.rd_valid & s_rd_ready_int;
    end

    // Slave-facing outputs. Read data reaches both masters unqualified.
    always_comb begin
        s.ar_valid  = ar_valid_q & reset;
        s.ar_addr   = addr_q;
        s.ar_prot   = prot_q;
        s.rd_ready  = s_rd_ready_int;
        m0.rd_data  = s.rd_data;
        m1.rd_data  = s.rd_data;
        state_dbg   = state;
    end

    // Arbitration FSM: IDLE grants, ADDR presents the request, DATA returns the beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            grant_m0   <= 1'b0;
            last_m0    <= 1'b0;
            drop       <= 1'b0;
            addr_q     <= '0;
            ar_valid_q <= 1'b0;
            prot_q     <= PROT_DATA;
        end else begin
            case (state)
                IDLE: begin
                    if (win0 | win1) begin
                        addr_q     <= win0 ? m0.ar_addr : m1.ar_addr;
                        grant_m0   <= win0;
                        last_m0    <= win0;
                        prot_q     <= win0 ? PROT_INSN : PROT_DATA;
                        ar_valid_q <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (grant_m0 && flush) begin
                        drop <= 1'b1;
                    end
                    if (s.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (grant_m0 && flush) begin
                        drop <= 1'b1;
                    end
                    // The end of the transaction clears any pending discard.
                    if (rd_hs) begin
                        drop  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed bench for axi_lite_rd_arbiter.
module tb_axi_lite_rd_arbiter;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       wr_pending;
    logic [1:0] state_dbg;

    int vectors;
    int miscompares;

    axi_lite_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
    axi_lite_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
    axi_lite_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

    axi_lite_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .wr_pending (wr_pending),
        .m0         (m0_if),
        .m1         (m1_if),
        .s          (s_if),
        .state_dbg  (state_dbg)
    );

    // Clock and a global watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one slave transaction from the ADDR state and checks routing.
    task automatic run_txn(input logic exp_m0, input logic [31:0] addr,
                           input logic [2:0] prot, input logic [31:0] data);
        chk("addr_state", {62'd0, state_dbg}, 64'd1);
        chk("s_ar_valid", {63'd0, s_if.ar_valid}, 64'd1);
        chk("s_ar_addr", {32'd0, s_if.ar_addr}, {32'd0, addr});
        chk("s_ar_prot", {61'd0, s_if.ar_prot}, {61'd0, prot});
        s_if.ar_ready = 1'b1;
        tick();
        s_if.ar_ready = 1'b0;
        s_if.rd_valid = 1'b1;
        s_if.rd_data  = data;
        settle();
        chk("s_ar_valid_off", {63'd0, s_if.ar_valid}, 64'd0);
        chk("m0_rd_valid", {63'd0, m0_if.rd_valid}, {63'd0, exp_m0});
        chk("m1_rd_valid", {63'd0, m1_if.rd_valid}, {63'd0, ~exp_m0});
        if (exp_m0) chk("m0_rd_data", {32'd0, m0_if.rd_data}, {32'd0, data});
        else        chk("m1_rd_data", {32'd0, m1_if.rd_data}, {32'd0, data});
        chk("s_rd_ready", {63'd0, s_if.rd_ready}, 64'd1);
        tick();
        s_if.rd_valid = 1'b0;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
        flush         = 1'b0;
        wr_pending    = 1'b0;
        m0_if.ar_valid = 1'b1;
        m0_if.ar_addr  = 32'h0;
        m0_if.ar_prot  = 3'b000;
        m0_if.rd_ready = 1'b1;
        m1_if.ar_valid = 1'b1;
        m1_if.ar_addr  = 32'h0;
        m1_if.ar_prot  = 3'b000;
        m1_if.rd_ready = 1'b1;
        s_if.ar_ready  = 1'b0;
        s_if.rd_valid  = 1'b0;
        s_if.rd_data   = 32'hAAAA_5555;

        // Reset state: requests present but nothing granted.
        tick();
        tick();
        settle();
        chk("rst_state", {62'd0, state_dbg}, 64'd0);
        chk("rst_m0_ar_ready", {63'd0, m0_if.ar_ready}, 64'd0);
        chk("rst_m1_ar_ready", {63'd0, m1_if.ar_ready}, 64'd0);
        chk("rst_s_ar_valid", {63'd0, s_if.ar_valid}, 64'd0);
        chk("rst_s_ar_prot", {61'd0, s_if.ar_prot}, 64'd0);
        chk("rst_rd_data_pass", {32'd0, m0_if.rd_data}, 64'hAAAA_5555);

        // Single M0 read.
        tick();
        reset = 1'b1;
        m1_if.ar_valid = 1'b0;
        m0_if.ar_addr  = 32'h8000_0000;
        settle();
        chk("single_m0_ar_ready", {63'd0, m0_if.ar_ready}, 64'd1);
        chk("single_m1_ar_ready", {63'd0, m1_if.ar_ready}, 64'd0);
        tick();
        m0_if.ar_valid = 1'b0;
        settle();
        chk("addr_m0_ar_ready", {63'd0, m0_if.ar_ready}, 64'd0);
        run_txn(1'b1, 32'h8000_0000, 3'b100, 32'h1234_5678);
        settle();
        chk("single_idle", {62'd0, state_dbg}, 64'd0);

        // Fairness from reset: both request continuously.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m0_if.ar_valid = 1'b1;
        m0_if.ar_addr  = 32'h0000_0100;
        m1_if.ar_valid = 1'b1;
        m1_if.ar_addr  = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_m0_ar_ready", {63'd0, m0_if.ar_ready}, {63'd0, (i % 2) == 0});
            chk("rr_m1_ar_ready", {63'd0, m1_if.ar_ready}, {63'd0, (i % 2) == 1});
            tick();
            settle();
            if ((i % 2) == 0) run_txn(1'b1, 32'h0000_0100, 3'b100, 32'hA000_0000 + i);
            else              run_txn(1'b0, 32'h0000_0200, 3'b000, 32'hB000_0000 + i);
        end
        m0_if.ar_valid = 1'b0;
        m1_if.ar_valid = 1'b0;

        // Flush during ADDR: transaction completes, beat discarded.
        m0_if.ar_valid = 1'b1;
        m0_if.ar_addr  = 32'h0000_0300;
        settle();
        chk("fl_m0_ar_ready", {63'd0, m0_if.ar_ready}, 64'd1);
        tick();
        m0_if.ar_valid = 1'b0;
        flush = 1'b1;
        settle();
        chk("fl_s_ar_valid", {63'd0, s_if.ar_valid}, 64'd1);
        tick();
        flush = 1'b0;
        s_if.ar_ready = 1'b1;
        settle();
        chk("fl_s_ar_valid_held", {63'd0, s_if.ar_valid}, 64'd1);
        tick();
        s_if.ar_ready = 1'b0;
        s_if.rd_valid = 1'b1;
        s_if.rd_data  = 32'hDEAD_BEEF;
        m0_if.rd_ready = 1'b0;
        settle();
        chk("fl_m0_rd_valid", {63'd0, m0_if.rd_valid}, 64'd0);
        chk("fl_s_rd_ready", {63'd0, s_if.rd_ready}, 64'd1);
        tick();
        s_if.rd_valid = 1'b0;
        m0_if.rd_ready = 1'b1;
        settle();
        chk("fl_idle", {62'd0, state_dbg}, 64'd0);
        m0_if.ar_valid = 1'b1;
        m0_if.ar_addr  = 32'h0000_0304;
        settle();
        chk("fl_next_ar_ready", {63'd0, m0_if.ar_ready}, 64'd1);
        tick();
        m0_if.ar_valid = 1'b0;
        settle();
        run_txn(1'b1, 32'h0000_0304, 3'b100, 32'h0304_0304);

        // wr_pending masks M1 even when M1 would win the tie.
        wr_pending = 1'b1;
        m0_if.ar_valid = 1'b1;
        m0_if.ar_addr  = 32'h0000_0400;
        m1_if.ar_valid = 1'b1;
        m1_if.ar_addr  = 32'h0000_0440;
        settle();
        chk("wp_m0_ar_ready", {63'd0, m0_if.ar_ready}, 64'd1);
        chk("wp_m1_ar_ready", {63'd0, m1_if.ar_ready}, 64'd0);
        tick();
        settle();
        run_txn(1'b1, 32'h0000_0400, 3'b100, 32'h4000_4000);
        wr_pending = 1'b0;
        settle();
        chk("wp_clr_m1_ar_ready", {63'd0, m1_if.ar_ready}, 64'd1);
        chk("wp_clr_m0_ar_ready", {63'd0, m0_if.ar_ready}, 64'd0);
        tick();
        m0_if.ar_valid = 1'b0;
        m1_if.ar_valid = 1'b0;
        settle();
        run_txn(1'b0, 32'h0000_0440, 3'b000, 32'h4400_4400);

        // M1 read with read-data backpressure.
        m1_if.ar_valid = 1'b1;
        m1_if.ar_addr  = 32'h0000_0500;
        m1_if.rd_ready = 1'b0;
        settle();
        chk("bp_m1_ar_ready", {63'd0, m1_if.ar_ready}, 64'd1);
        tick();
        m1_if.ar_valid = 1'b0;
        s_if.ar_ready  = 1'b1;
        tick();
        s_if.ar_ready = 1'b0;
        s_if.rd_valid = 1'b1;
        s_if.rd_data  = 32'h5555_0500;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_state", {62'd0, state_dbg}, 64'd2);
            chk("bp_s_rd_ready", {63'd0, s_if.rd_ready}, 64'd0);
            chk("bp_m1_rd_valid", {63'd0, m1_if.rd_valid}, 64'd1);
            chk("bp_m1_rd_data", {32'd0, m1_if.rd_data}, 64'h5555_0500);
            tick();
        end
        m1_if.rd_ready = 1'b1;
        settle();
        chk("bp_s_rd_ready_up", {63'd0, s_if.rd_ready}, 64'd1);
        tick();
        s_if.rd_valid = 1'b0;
        settle();
        chk("bp_idle", {62'd0, state_dbg}, 64'd0);

        // Reset during DATA, then the first tie goes to M0.
        m0_if.ar_valid = 1'b1;
        m0_if.ar_addr  = 32'h0000_0600;
        tick();
        m0_if.ar_valid = 1'b0;
        s_if.ar_ready  = 1'b1;
        tick();
        s_if.ar_ready = 1'b0;
        settle();
        chk("mr_in_data", {62'd0, state_dbg}, 64'd2);
        reset = 1'b0;
        m0_if.ar_valid = 1'b1;
        m1_if.ar_valid = 1'b1;
        m0_if.ar_addr  = 32'h0000_0700;
        m1_if.ar_addr  = 32'h0000_0780;
        tick();
        settle();
        chk("mr_state", {62'd0, state_dbg}, 64'd0);
        chk("mr_s_ar_valid", {63'd0, s_if.ar_valid}, 64'd0);
        chk("mr_s_rd_ready", {63'd0, s_if.rd_ready}, 64'd0);
        chk("mr_m0_ar_ready", {63'd0, m0_if.ar_ready}, 64'd0);
        chk("mr_m1_ar_ready", {63'd0, m1_if.ar_ready}, 64'd0);
        chk("mr_m0_rd_valid", {63'd0, m0_if.rd_valid}, 64'd0);
        reset = 1'b1;
        settle();
        chk("mr_tie_m0", {63'd0, m0_if.ar_ready}, 64'd1);
        chk("mr_tie_m1", {63'd0, m1_if.ar_ready}, 64'd0);
        tick();
        m0_if.ar_valid = 1'b0;
        m1_if.ar_valid = 1'b0;
        settle();
        run_txn(1'b1, 32'h0000_0700, 3'b100, 32'h0700_0700);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
